// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event generator: the FSM state type,
// default timing constants, and a small helper used to size the tick counter.
// -----------------------------------------------------------------------------
package button_pkg;

  // Event FSM states. REPEAT is only reachable when auto-repeat is compiled in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } button_state_t;

  // Default timing, in clock cycles, for the top level and for benches.
  localparam int BUTTON_HOLD_CYCLES_DEFAULT   = 32'sd500;
  localparam int BUTTON_REPEAT_CYCLES_DEFAULT = 32'sd100;

  // Largest legal value of either timing parameter (2^24).
  localparam int BUTTON_CYCLES_MAX = 32'sd16777216;

  // Larger of two integers; used to size the shared hold/repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
// Turns the debounced button level into one-cycle event strobes: press,
// release and hold-to-repeat. The input is already synchronous and clean, so
// it is sampled directly without a synchronizer.
//
// Configuration macro: BUTTON_EVENT_REPEAT_EN
//   defined   - full behaviour, including the REPEAT state and repeat strobes.
//   undefined - no REPEAT state and no counter; repeat_o is tied low, while
//               press_o, release_o and held_o behave exactly as when defined.
//
// Parameters:
//   HOLD_CYCLES   - edges from the press edge to the first repeat (2..2^24)
//   REPEAT_CYCLES - edges between successive repeats (2..2^24)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   in_i      in   debounced button level, 1 = pressed
//   press_o   out  one-cycle pulse when the button is pressed
//   release_o out  one-cycle pulse when the button is released
//   repeat_o  out  one-cycle pulse per auto-repeat tick
//   held_o    out  high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module button_event
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = BUTTON_HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES = BUTTON_REPEAT_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_i,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic held_o
);

  // One counter serves both the hold delay and the repeat period, so it is
  // sized for whichever is longer. It is cleared at its terminal value and
  // therefore never wraps.
  localparam int COUNTER_BITS = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  // Reject out-of-range timing at elaboration rather than misbehave silently.
  generate
    if ((HOLD_CYCLES < 32'sd2) || (HOLD_CYCLES > BUTTON_CYCLES_MAX) ||
        (REPEAT_CYCLES < 32'sd2) || (REPEAT_CYCLES > BUTTON_CYCLES_MAX) ||
        (COUNTER_BITS < 32'sd1)) begin : g_bad_params
      $error("button_event: HOLD_CYCLES and REPEAT_CYCLES must be in 2..2^24");
    end
  endgenerate

  button_state_t state_q, state_d;
  logic          press_q,   press_d;
  logic          release_q, release_d;
  logic          repeat_q,  repeat_d;
  logic          held_q,    held_d;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [COUNTER_BITS-1:0] HOLD_LAST   = COUNTER_BITS'(HOLD_CYCLES - 32'sd1);
  localparam logic [COUNTER_BITS-1:0] REPEAT_LAST = COUNTER_BITS'(REPEAT_CYCLES - 32'sd1);

  logic [COUNTER_BITS-1:0] counter_q, counter_d;
`endif

  // Next-state and next-output logic for the event FSM.
  // Release is tested before the terminal count so that a falling input on
  // the terminal edge produces only a release strobe.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    counter_d = counter_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_i) begin
          press_d = 1'b1;
          state_d = HELD;
`ifdef BUTTON_EVENT_REPEAT_EN
          counter_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      HELD: begin
        if (!in_i) begin
          release_d = 1'b1;
          state_d   = IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
          counter_d = '0;
        end else if (counter_q == HOLD_LAST) begin
          repeat_d  = 1'b1;
          state_d   = REPEAT;
          counter_d = '0;
        end else begin
          counter_d = counter_q + COUNTER_BITS'(1);
`else
        end else begin
          state_d = HELD;
`endif
        end
      end

`ifdef BUTTON_EVENT_REPEAT_EN
      REPEAT: begin
        if (!in_i) begin
          release_d = 1'b1;
          state_d   = IDLE;
          counter_d = '0;
        end else if (counter_q == REPEAT_LAST) begin
          repeat_d  = 1'b1;
          counter_d = '0;
        end else begin
          counter_d = counter_q + COUNTER_BITS'(1);
        end
      end
`endif

      default: begin
        // Unreachable encodings recover to IDLE without emitting events.
        state_d = IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
        counter_d = '0;
`endif
      end
    endcase

    // held tracks the state being entered so it rises with press and falls
    // with release in the same cycle as those strobes.
    held_d = (state_d != IDLE);
  end

  // State, counter and registered outputs; reset discards any hold silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      counter_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
`ifdef BUTTON_EVENT_REPEAT_EN
      counter_q <= counter_d;
`endif
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign held_o    = held_q;

`ifdef BUTTON_EVENT_REPEAT_EN
  assign repeat_o = repeat_q;
`else
  // repeat_d is constant 0 without auto-repeat; the register folds away.
  assign repeat_o = 1'b0 & repeat_q;
`endif

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
Converts the clean level from the button debouncer into single-cycle event pulses: press, release, and hold-to-repeat.
- Sits directly downstream of the debouncer.
- Feeds the operand-entry and control logic, which consumes only one-cycle strobes.
- The input is already synchronous and glitch-free, so no synchronizer is needed here.

Parameters:
- HOLD_CYCLES, 500: cycles the button must stay held after press before the first repeat pulse; legal values 2 to 2^24.
- REPEAT_CYCLES, 100: period in cycles between successive repeat pulses once repeating; legal values 2 to 2^24.
- COUNTER_BITS: localparam, $clog2 of the larger of HOLD_CYCLES and REPEAT_CYCLES; never overridden.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  1  debounced button level, 1 = pressed, synchronous to clock.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- repeat  output  1  one-cycle pulse per auto-repeat tick.
- held  output  1  high while the button is considered held (state is not IDLE).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are named clock and reset_n.
- Reset: state=IDLE, counter=0; press, release, repeat and held all 0. Reset applies immediately and asynchronously. Reset mid-hold discards the hold; no release pulse is generated.
- All outputs are registered. Each event pulse appears in the cycle after the edge at which the causing condition is sampled.
- States: IDLE, HELD, REPEAT, encoded via an enum typedef.
- IDLE:
  - in=1 at edge: press<=1, state<=HELD, counter<=0.
  - Otherwise stay in IDLE.
- HELD:
  - in=0 at edge: release<=1, state<=IDLE, counter<=0.
  - in=1 and counter==HOLD_CYCLES-1: repeat<=1, state<=REPEAT, counter<=0.
  - Otherwise counter<=counter+1.
- REPEAT:
  - in=0 at edge: release<=1, state<=IDLE, counter<=0.
  - in=1 and counter==REPEAT_CYCLES-1: repeat<=1, counter<=0.
  - Otherwise counter<=counter+1.
- Timing: the first repeat occurs HOLD_CYCLES edges after the press edge. Later repeats occur every REPEAT_CYCLES edges.
- Priority: release beats repeat. If in falls at the edge where the counter hits terminal, only release fires.
- Pulses are one cycle wide and deasserted every other cycle. press, release and repeat are mutually exclusive in any cycle.
- held is registered and equals (state != IDLE). It rises with press and falls with release.
- Minimum press (in high for one edge, low at the next): press at cycle N+1, release at cycle N+2, no repeat.
- The counter never wraps: it is reset at its terminal value, and COUNTER_BITS covers the larger parameter.
- A new press is accepted immediately after release; IDLE has no dead time.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: full behaviour as above.
- Undefined:
  - REPEAT state and repeat counter logic are not compiled.
  - HELD has no terminal transition, and the counter is omitted entirely.
  - repeat is tied to 0; port list is unchanged.
  - press, release and held behave identically to the defined case.

Decomposition:
- Shared package button_pkg holds the state enum typedef button_state_t {IDLE, HELD, REPEAT}.
- Default timing constants live alongside it for use by the top level and benches.
- No sub-module: a single FSM plus one counter in one module.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=3, macro defined unless stated):
1. Reset asserted mid-REPEAT with in held 1 -> all outputs 0 immediately; after deassert with in still 1 -> press fires once at the next edge+1.
2. in=1 sampled at edge 0, held through edge 11 -> press after edge 0; repeat after edges 4, 7 and 10; held=1 throughout; no release.
3. in=1 at edge 0 only, 0 at edge 1 -> press in cycle 1, release in cycle 2, repeat never.
4. in=1 edges 0-3, 0 at edge 4 (terminal coincidence) -> release after edge 4, no repeat pulse.
5. Release then re-press at the next edge (in 0 at edge 6, 1 at edge 7) -> release cycle 7, press cycle 8, counter restarts; first repeat after edge 11.
6. Macro undefined, in held 1 for 20 edges then 0 -> exactly one press and one release; repeat stays 0; held spans the whole interval.
